// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, ExcCode values, Status/Cause
// bit positions, the sequencing state type and a restart-PC helper.
package cp0_pkg;

    // MFC0/MTC0 register numbers (select 0)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_EBASE    = 5'd15;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status bit positions; only IM[15:8], EXL and IE exist
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    // Cause bit positions
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_BD      = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    // Restart address: a delay-slot instruction restarts at its branch.
    function automatic logic [31:0] restart_pc(input logic [31:0] pc,
                                               input logic        in_delay);
        return in_delay ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   count_we_i        MTC0 to Count (loads wdata_i, suppresses the increment)
//   compare_we_i      MTC0 to Compare (loads wdata_i, clears timer_pend_o)
//   wdata_i           MTC0 write data
//   count_o           current Count
//   compare_o         current Compare
//   timer_pend_o      sticky timer interrupt request
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_pend_o
);

    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        pend_q,    pend_d;

    always_comb begin
        count_d   = count_we_i   ? wdata_i : (count_q + 32'd1);
        compare_d = compare_we_i ? wdata_i : compare_q;
        // Match is taken on the post-update Count; a Compare write wins
        // over a coincident match so software can always acknowledge.
        if (compare_we_i) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q | (count_d == compare_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            pend_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
        end
    end

    assign count_o      = count_q;
    assign compare_o    = compare_q;
    assign timer_pend_o = pend_q;

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 register file and exception / interrupt / ERET sequencer for a
// five-stage MIPS32 pipeline. Events are committed from MEM; MTC0 comes
// from WB. An accepted event updates CP0 at its edge, then one FLUSH
// cycle (flush + redirect) and one RECOVER cycle follow.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   hw_int[5:0]                      level interrupt lines
//   mem_valid, mem_pc, mem_in_delay  MEM-stage instruction info
//   exc_valid, exc_code, exc_badvaddr  synchronous exception from MEM
//   eret_valid                       MEM-stage ERET
//   cp0_we, cp0_waddr, cp0_wdata     MTC0 write port
//   cp0_raddr, cp0_rdata             MFC0 read port (combinational)
//   status_o, cause_o, epc_o, ebase_o  register values for forwarding
//   flush, redirect_valid, redirect_pc  pipeline kill / PC redirect
//   busy                             sequencer not IDLE
module cp0_exception_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] RESET_EBASE = 32'h8000_0000,
    parameter logic [31:0] EXC_OFFSET  = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delay,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_valid,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] ebase_o,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [31:0] status_q,   status_d;
    logic [31:0] epc_q,      epc_d;
    logic [31:0] ebase_q,    ebase_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        bd_q,       bd_d;
    logic [4:0]  exc_q,      exc_d;
    logic [1:0]  swip_q,     swip_d;
    logic [5:0]  hw_int_q;
    logic        flush_q,    redirect_valid_q;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [31:0] count, compare;
    logic        timer_pend;
    logic        wr_count, wr_compare;
    logic [7:0]  cause_ip;
    logic [7:0]  ip_live;
    logic        int_req;
    logic        take_int, take_exc, take_eret, accept;
    logic [31:0] cause_val;

    assign wr_count   = cp0_we && (cp0_waddr == CP0_COUNT);
    assign wr_compare = cp0_we && (cp0_waddr == CP0_COMPARE);

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (wr_count),
        .compare_we_i (wr_compare),
        .wdata_i      (cp0_wdata),
        .count_o      (count),
        .compare_o    (compare),
        .timer_pend_o (timer_pend)
    );

    // IP7 merges the timer with hw_int[5]; the hardware lines are taken
    // from a per-cycle sample so Cause is a pure function of register state.
    assign cause_ip  = {hw_int_q[5] | timer_pend, hw_int_q[4:0], swip_q};
    assign cause_val = {bd_q, 15'd0, cause_ip, 1'b0, exc_q, 2'b00};

    for (genvar gi = 0; gi < 8; gi++) begin : g_ip
        assign ip_live[gi] = cause_ip[gi] & status_q[STATUS_IM_LSB + gi];
    end

    assign int_req = (|ip_live) & status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                     & mem_valid;

    // FSM: events are only looked at in IDLE; anything arriving in FLUSH or
    // RECOVER belongs to an instruction that is being squashed.
    always_comb begin
        state_d   = state_q;
        take_int  = 1'b0;
        take_exc  = 1'b0;
        take_eret = 1'b0;
        case (state_q)
            IDLE: begin
                take_int  = int_req;
                take_exc  = ~int_req & exc_valid;
                take_eret = ~int_req & ~exc_valid & eret_valid;
                if (take_int || take_exc || take_eret) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept = take_int | take_exc | take_eret;

    // Register next-state: MTC0 first, then event updates override the
    // fields they own.
    always_comb begin
        status_d      = status_q;
        epc_d         = epc_q;
        ebase_d       = ebase_q;
        badvaddr_d    = badvaddr_q;
        bd_d          = bd_q;
        exc_d         = exc_q;
        swip_d        = swip_q;
        redirect_pc_d = redirect_pc_q;

        // BadVAddr has no write path: it is hardware-owned.
        if (cp0_we) begin
            case (cp0_waddr)
                CP0_STATUS: status_d = cp0_wdata & STATUS_WMASK;
                CP0_CAUSE:  swip_d   = cp0_wdata[CAUSE_IP_LSB +: 2];
                CP0_EPC:    epc_d    = cp0_wdata;
                CP0_EBASE:  ebase_d  = cp0_wdata;
                default: ;
            endcase
        end

        if (take_int || take_exc) begin
            epc_d                = restart_pc(mem_pc, mem_in_delay);
            bd_d                 = mem_in_delay;
            exc_d                = take_int ? EXC_INT : exc_code;
            status_d[STATUS_EXL] = 1'b1;
            if (take_exc && ((exc_code == EXC_ADEL) || (exc_code == EXC_ADES))) begin
                badvaddr_d = exc_badvaddr;
            end
            redirect_pc_d = ebase_d + EXC_OFFSET;
        end else if (take_eret) begin
            status_d[STATUS_EXL] = 1'b0;
            // epc_d already carries a same-cycle MTC0 to EPC
            redirect_pc_d = epc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            status_q         <= 32'd0;
            epc_q            <= 32'd0;
            ebase_q          <= RESET_EBASE;
            badvaddr_q       <= 32'd0;
            bd_q             <= 1'b0;
            exc_q            <= 5'd0;
            swip_q           <= 2'd0;
            hw_int_q         <= 6'd0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            state_q          <= state_d;
            status_q         <= status_d;
            epc_q            <= epc_d;
            ebase_q          <= ebase_d;
            badvaddr_q       <= badvaddr_d;
            bd_q             <= bd_d;
            exc_q            <= exc_d;
            swip_q           <= swip_d;
            hw_int_q         <= hw_int;
            flush_q          <= accept;
            redirect_valid_q <= accept;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    always_comb begin
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = count;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS:   cp0_rdata = status_q;
            CP0_CAUSE:    cp0_rdata = cause_val;
            CP0_EPC:      cp0_rdata = epc_q;
            CP0_EBASE:    cp0_rdata = ebase_q;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign status_o       = status_q;
    assign cause_o        = cause_val;
    assign epc_o          = epc_q;
    assign ebase_o        = ebase_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: doc/cp0_exception_ctrl.md
# cp0_exception_ctrl

Owns the CP0 architectural registers (Count, Compare, Status, Cause, EPC, EBase, BadVAddr) and sequences exception entry, interrupt entry and ERET for the five-stage MIPS32 pipeline. It sits beside the MEM stage, where exceptions are committed, and takes MTC0 writes from WB. Its register outputs feed the EX-stage CP0 forwarding unit. It drives pipeline flush and PC redirect.

## Interface
- RESET_EBASE, 32'h8000_0000, EBase value after reset
- EXC_OFFSET, 32'h0000_0180, general exception vector offset added to EBase
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hw_int  in  6  external interrupt lines, level-sensitive, sampled each cycle
- mem_valid  in  1  MEM stage holds a real (non-bubble) instruction
- mem_pc  in  32  PC of MEM-stage instruction
- mem_in_delay  in  1  MEM-stage instruction is in a branch delay slot
- exc_valid  in  1  MEM-stage instruction raised a synchronous exception
- exc_code  in  5  ExcCode of that exception
- exc_badvaddr  in  32  faulting address, used for AdEL/AdES only
- eret_valid  in  1  MEM-stage instruction is ERET
- cp0_we, cp0_waddr, cp0_wdata  in  1/5/32  MTC0 write from WB
- cp0_raddr  in  5  MFC0 read address
- cp0_rdata  out  32  combinational read of the addressed register; 0 for unimplemented addresses
- status_o, cause_o, epc_o, ebase_o  out  32 each  current register values for forwarding
- flush  out  1  kill IF/ID/EX/MEM contents
- redirect_valid  out  1  load redirect_pc into PC
- redirect_pc  out  32  new fetch address
- busy  out  1  high while state is not IDLE

## Operation
- Addresses: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, EBase 15.
- Status writable bits: IM[15:8], EXL[1], IE[0]. All other bits read 0.
- Cause fields:
  - BD[31] and ExcCode[6:2] are written by hardware only.
  - IP[15:10] = {hw_int[5] | timer_pend, hw_int[4:0]}, refreshed every cycle.
  - IP[9:8] are software-writable.
- Count increments by 1 every cycle and wraps at 2^32.
- When Count == Compare (after the increment), timer_pend sets and stays set.
- A write to Compare clears timer_pend.
- An MTC0 to Count loads the written value in that cycle; no increment in that cycle.
- Interrupt pending: int_req = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL & mem_valid.
- Priority in IDLE: int_req, then exc_valid, then eret_valid.
- Exception/interrupt entry:
  - EPC = mem_in_delay ? mem_pc-4 : mem_pc; BD = mem_in_delay.
  - ExcCode = 0 for an interrupt, else exc_code.
  - EXL = 1.
  - BadVAddr = exc_badvaddr when exc_code is 4 or 5.
  - Target = EBase + EXC_OFFSET.
- ERET: EXL = 0; target = EPC as it is after this edge's updates.
- Same-cycle MTC0 and entry: apply the MTC0 first, then the entry field updates override the fields they touch.
- An MTC0 to EPC in the same cycle as ERET is visible in the redirect target.
- State machine (state_t):
  - IDLE → FLUSH when any event is accepted.
  - FLUSH → RECOVER unconditionally.
  - RECOVER → IDLE unconditionally.
- Events (exc_valid, eret_valid, int_req) are ignored in FLUSH and RECOVER; they belong to squashed instructions.
- MTC0 writes and the Count/timer logic continue in every state.

## Timing
- An event is sampled in IDLE at cycle T. CP0 fields update at the T edge.
- In T+1 (FLUSH): flush = 1, redirect_valid = 1, redirect_pc valid.
- In T+2 (RECOVER): flush = 0, redirect_valid = 0.
- IDLE again at T+3. Minimum spacing between two accepted events is 3 cycles.
- flush and redirect_valid are registered outputs, each high for exactly 1 cycle.
- cp0_rdata and the *_o outputs reflect register state after the last edge; there is no internal bypass.
- Reset values:
  - All registers 0, except EBase = RESET_EBASE.
  - timer_pend = 0; state = IDLE.
  - flush, redirect_valid and busy = 0; redirect_pc = 0.
- rst asserted mid-sequence returns to IDLE on the next edge; no redirect is issued afterwards.

## Structure
- Shared package cp0_pkg holds:
  - register address constants
  - ExcCode constants (Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12)
  - Status/Cause bit-position constants
  - state_t enum {IDLE, FLUSH, RECOVER}
- Sub-module cp0_timer contains Count, Compare and timer_pend, plus the Count/Compare write ports.

## Test plan
- Syscall: exc_valid=1, exc_code=8, mem_pc=0x8000_0100, EBase reset → EPC=0x8000_0100, ExcCode=8, EXL=1; flush/redirect at T+1 with redirect_pc=0x8000_0180; busy for 2 cycles.
- Delay-slot AdEL: mem_in_delay=1, mem_pc=0x8000_0204, exc_badvaddr=0x1235 → EPC=0x8000_0200, BD=1, BadVAddr=0x1235.
- Timer interrupt: Status=0x0000_8001, Compare=20, mem_valid=1 → timer_pend sets when Count==20; interrupt entry with ExcCode=0; a Compare write clears Cause[15].
- Masking: hw_int[0]=1 with EXL=1, or IM[10]=0 → no entry. After ERET clears EXL, with IM[10]=1 → entry within 1 cycle of IDLE.
- Simultaneous events: int_req, exc_valid and eret_valid in the same cycle → interrupt taken. exc_valid during FLUSH/RECOVER → ignored.
- MTC0 EPC=0x8000_4000 in the same cycle as ERET → redirect_pc=0x8000_4000; rst asserted in FLUSH → next cycle state IDLE, all outputs at reset values.
